bus_transfer_decoder: RTL and testbench

- Sequenced decoder for the datapath bus: takes one register-transfer micro-op (5-bit source code, 5-bit destination code) per valid/ready handshake.
- Expands each code into one-hot "out" (bus-drive) and "in" (latch-enable) strobes for the 24 bus endpoints.
- Sits between the control unit and the register file / special registers; its src_oh drives the bus-mux encoder inputs.
- Times each transfer: source drives the bus for a settle period, then the destination latches.

---
 rtl/bus_transfer_decoder.sv | 139 +++++++++++++
 tb/tb_bus_transfer_decoder.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : bus_transfer_decoder
//  Brief    : Sequenced register-transfer decoder. Expands a (src, dst) code
//             pair into one-hot bus-drive / latch-enable strobes, holding the
//             source alone for SETTLE_CYCLES before a one-cycle latch.
//             Optional loopback self-check: BUSMUX_DEC_LOOPBACK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module bus_transfer_decoder #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [4:0]  op_src,
    input  logic [4:0]  op_dst,
    output logic [23:0] src_oh,
    output logic [23:0] dst_oh,
    output logic        done,
    output logic        err,
    output logic        chk_err
);

    localparam logic [4:0] c_SRC_MAX = 5'd23;
    localparam logic [4:0] c_DST_MAX = 5'd21;
    localparam logic [3:0] c_LOAD    = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_LATCH  = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_src;
    logic [4:0]  r_dst;
    logic [3:0]  r_count;
    logic [23:0] r_src_oh;
    logic [23:0] r_dst_oh;
    logic        r_done;
    logic        r_err;

    logic        w_accept;
    logic        w_legal;

    // Codes above 23 shift the single bit out of range, yielding all zeros.
    function automatic logic [23:0] f_onehot(input logic [4:0] code);
        return 24'd1 << code;
    endfunction

    assign op_ready = clear && ((r_state == S_IDLE) || (r_state == S_LATCH));
    assign w_accept = op_valid && op_ready;
    assign w_legal  = (op_src <= c_SRC_MAX) && (op_dst <= c_DST_MAX);

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state  <= S_IDLE;
            r_src    <= 5'd0;
            r_dst    <= 5'd0;
            r_count  <= 4'd0;
            r_src_oh <= 24'd0;
            r_dst_oh <= 24'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_dst_oh <= 24'd0;
            case (r_state)
                S_SETTLE: begin
                    r_src_oh <= f_onehot(r_src);
                    if (r_count == 4'd0) begin
                        r_state  <= S_LATCH;
                        r_dst_oh <= f_onehot(r_dst);
                        r_done   <= 1'b1;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                S_IDLE, S_LATCH: begin
                    // A legal op accepted in LATCH chains straight into SETTLE.
                    r_state  <= S_IDLE;
                    r_src_oh <= 24'd0;
                    if (w_accept) begin
                        if (w_legal) begin
                            r_src    <= op_src;
                            r_dst    <= op_dst;
                            r_count  <= c_LOAD;
                            r_state  <= S_SETTLE;
                            r_src_oh <= f_onehot(op_src);
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_src_oh <= 24'd0;
                end
            endcase
        end
    end

    assign src_oh = r_src_oh;
    assign dst_oh = r_dst_oh;
    assign done   = r_done;
    assign err    = r_err;

`ifdef BUSMUX_DEC_LOOPBACK_EN
    logic [4:0] w_enc;
    logic       r_chk_err;

    // Priority re-encode: descending scan so the lowest set index wins.
    always_comb begin
        w_enc = 5'd0;
        for (int i = 23; i >= 0; i--) begin
            if (r_src_oh[i]) begin
                w_enc = 5'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_chk_err <= 1'b0;
        end else if ((r_src_oh != 24'd0) && (w_enc != r_src)) begin
            r_chk_err <= 1'b1;
        end
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_transfer_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_transfer_decoder
//  Brief    : Scoreboard bench for bus_transfer_decoder (main DUT SETTLE=3,
//             plus a SETTLE=1 instance for the basic latency case).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_transfer_decoder;

    localparam int S = 3;

    logic        clock = 1'b0;
    logic        clear;
    logic        op_valid;
    logic [4:0]  op_src;
    logic [4:0]  op_dst;
    logic        op_ready;
    logic [23:0] src_oh;
    logic [23:0] dst_oh;
    logic        done;
    logic        err;
    logic        chk_err;

    logic        s1_valid;
    logic [4:0]  s1_src;
    logic [4:0]  s1_dst;
    logic        s1_ready;
    logic [23:0] s1_src_oh;
    logic [23:0] s1_dst_oh;
    logic        s1_done;
    logic        s1_err;
    logic        s1_chk_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic        is_err;
        logic [23:0] s;
        logic [23:0] d;
        int          due;
    } exp_t;
    exp_t sbq[$];

    always #5 clock = ~clock;

    bus_transfer_decoder #(.SETTLE_CYCLES(S)) u_dut (
        .clock(clock), .clear(clear), .op_valid(op_valid), .op_ready(op_ready),
        .op_src(op_src), .op_dst(op_dst), .src_oh(src_oh), .dst_oh(dst_oh),
        .done(done), .err(err), .chk_err(chk_err)
    );

    bus_transfer_decoder #(.SETTLE_CYCLES(1)) u_dut_s1 (
        .clock(clock), .clear(clear), .op_valid(s1_valid), .op_ready(s1_ready),
        .op_src(s1_src), .op_dst(s1_dst), .src_oh(s1_src_oh), .dst_oh(s1_dst_oh),
        .done(s1_done), .err(s1_err), .chk_err(s1_chk_err)
    );

    // Push expected transfer on every accepted handshake; reset abandons all.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!clear) begin
            sbq.delete();
        end else if (op_valid && op_ready) begin
            exp_t e;
            e.is_err = !((op_src <= 5'd23) && (op_dst <= 5'd21));
            e.s      = e.is_err ? 24'd0 : (24'd1 << op_src);
            e.d      = e.is_err ? 24'd0 : (24'd1 << op_dst);
            e.due    = e.is_err ? cyc + 1 : cyc + 1 + S;
            sbq.push_back(e);
        end
    end

    // Pop and compare whenever the DUT reports a completion or rejection.
    always @(negedge clock) begin
        if (clear === 1'b1) begin
            if (done || err) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected cyc=%0d done=%b err=%b src_oh=%h dst_oh=%h",
                             cyc, done, err, src_oh, dst_oh);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (err !== e.is_err || done !== !e.is_err || cyc != e.due ||
                        src_oh !== e.s || dst_oh !== e.d) begin
                        errors++;
                        $display("FAIL sb_entry got cyc=%0d err=%b done=%b src=%h dst=%h want cyc=%0d err=%b src=%h dst=%h",
                                 cyc, err, done, src_oh, dst_oh, e.due, e.is_err, e.s, e.d);
                    end
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
                checks++;
                errors++;
                $display("FAIL sb_missing cyc=%0d want due=%0d", cyc, sbq[0].due);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!op_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!op_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got op_ready=%b want 1", op_ready);
        end
    endtask

    // Returns at the negedge of the first cycle after acceptance.
    task automatic send(input logic [4:0] s, input logic [4:0] d);
        op_valid = 1'b1;
        op_src   = s;
        op_dst   = d;
        wait_ready();
        @(negedge clock);
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b0; op_valid = 1'b1; op_src = 5'd2; op_dst = 5'd3;
        s1_valid = 1'b0; s1_src = 5'd0; s1_dst = 5'd0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (op_ready !== 1'b0 || src_oh !== 24'd0 || dst_oh !== 24'd0 ||
            done !== 1'b0 || err !== 1'b0 || chk_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got rdy=%b src=%h dst=%h done=%b err=%b chk=%b want all 0",
                     op_ready, src_oh, dst_oh, done, err, chk_err);
        end
        op_valid = 1'b0;
        clear    = 1'b1;
        @(negedge clock);
        checks++;
        if (op_ready !== 1'b1 || src_oh !== 24'd0 || dst_oh !== 24'd0 || done !== 1'b0 ||
            s1_ready !== 1'b1 || s1_src_oh !== 24'd0 || s1_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b src=%h done=%b s1rdy=%b want rdy=1 zeros",
                     op_ready, src_oh, done, s1_ready);
        end
    endtask

    task automatic test_basic_s1();
        s1_valid = 1'b1; s1_src = 5'd5; s1_dst = 5'd20;
        @(negedge clock);
        s1_valid = 1'b0;
        checks++;
        if (s1_src_oh !== 24'h000020 || s1_dst_oh !== 24'd0 || s1_done !== 1'b0) begin
            errors++;
            $display("FAIL s1_settle got src=%h dst=%h done=%b want 000020 000000 0",
                     s1_src_oh, s1_dst_oh, s1_done);
        end
        @(negedge clock);
        checks++;
        if (s1_src_oh !== 24'h000020 || s1_dst_oh !== 24'h100000 || s1_done !== 1'b1) begin
            errors++;
            $display("FAIL s1_latch got src=%h dst=%h done=%b want 000020 100000 1",
                     s1_src_oh, s1_dst_oh, s1_done);
        end
        @(negedge clock);
        checks++;
        if (s1_src_oh !== 24'd0 || s1_dst_oh !== 24'd0 || s1_done !== 1'b0 || s1_ready !== 1'b1) begin
            errors++;
            $display("FAIL s1_idle got src=%h dst=%h done=%b rdy=%b want 0 0 0 1",
                     s1_src_oh, s1_dst_oh, s1_done, s1_ready);
        end
    endtask

    task automatic test_transfer();
        logic [4:0] srcs [5] = '{5'd5, 5'd0, 5'd23, 5'd19, 5'd22};
        logic [4:0] dsts [5] = '{5'd20, 5'd21, 5'd0, 5'd16, 5'd17};
        for (int i = 0; i < 5; i++) begin
            send(srcs[i], dsts[i]);
            checks++;
            if (src_oh !== (24'd1 << srcs[i]) || dst_oh !== 24'd0 || op_ready !== 1'b0) begin
                errors++;
                $display("FAIL xfer_settle[%0d] got src=%h dst=%h rdy=%b want src=%h dst=0 rdy=0",
                         i, src_oh, dst_oh, op_ready, 24'd1 << srcs[i]);
            end
            repeat (S + 1) @(negedge clock);
        end
        checks++;
        if (chk_err !== 1'b0) begin
            errors++;
            $display("FAIL xfer_chk got chk_err=%b want 0", chk_err);
        end
    endtask

    task automatic test_back_to_back();
        op_valid = 1'b1; op_src = 5'd16; op_dst = 5'd1;
        wait_ready();
        @(negedge clock);
        op_src = 5'd21; op_dst = 5'd0;
        for (int i = 1; i <= S + 1; i++) begin
            if (i > 1) @(negedge clock);
            checks++;
            if (src_oh !== 24'h010000 ||
                dst_oh !== ((i == S + 1) ? 24'h000002 : 24'd0) ||
                op_ready !== (i == S + 1)) begin
                errors++;
                $display("FAIL b2b_first[%0d] got src=%h dst=%h rdy=%b want 010000 %h %b",
                         i, src_oh, dst_oh, op_ready,
                         (i == S + 1) ? 24'h000002 : 24'd0, i == S + 1);
            end
        end
        @(negedge clock);
        op_valid = 1'b0;
        checks++;
        if (src_oh !== 24'h200000 || dst_oh !== 24'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got src=%h dst=%h done=%b want 200000 0 0",
                     src_oh, dst_oh, done);
        end
        repeat (S + 1) @(negedge clock);
    endtask

    task automatic test_illegal();
        logic [4:0] srcs [4] = '{5'd0, 5'd25, 5'd4, 5'd31};
        logic [4:0] dsts [4] = '{5'd22, 5'd3, 5'd23, 5'd31};
        for (int i = 0; i < 4; i++) begin
            op_valid = 1'b1; op_src = srcs[i]; op_dst = dsts[i];
            wait_ready();
            @(negedge clock);
            op_valid = 1'b0;
            checks++;
            if (err !== 1'b1 || src_oh !== 24'd0 || dst_oh !== 24'd0 || op_ready !== 1'b1) begin
                errors++;
                $display("FAIL illegal[%0d] got err=%b src=%h dst=%h rdy=%b want 1 0 0 1",
                         i, err, src_oh, dst_oh, op_ready);
            end
            @(negedge clock);
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL illegal_pulse[%0d] got err=%b want 0", i, err);
            end
        end
        // Illegal op arriving in the LATCH cycle of a legal transfer.
        op_valid = 1'b1; op_src = 5'd2; op_dst = 5'd3;
        wait_ready();
        @(negedge clock);
        op_dst = 5'd22;
        wait_ready();
        @(negedge clock);
        op_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || src_oh !== 24'd0 || dst_oh !== 24'd0 || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_latch got err=%b src=%h dst=%h rdy=%b want 1 0 0 1",
                     err, src_oh, dst_oh, op_ready);
        end
        @(negedge clock);
    endtask

    task automatic test_self();
        int n = 0;
        send(5'd7, 5'd7);
        while (!done && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (done !== 1'b1 || src_oh !== 24'h000080 || dst_oh !== 24'h000080) begin
            errors++;
            $display("FAIL self_xfer got done=%b src=%h dst=%h want 1 000080 000080",
                     done, src_oh, dst_oh);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        send(5'd3, 5'd4);
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        checks++;
        if (src_oh !== 24'd0 || dst_oh !== 24'd0 || done !== 1'b0 || err !== 1'b0 ||
            op_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset got src=%h dst=%h done=%b err=%b rdy=%b want all 0",
                     src_oh, dst_oh, done, err, op_ready);
        end
        clear = 1'b1;
        for (int i = 0; i < S + 3; i++) begin
            @(negedge clock);
            if (done || dst_oh[4]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abandon got done/dst4 seen=%b want 0", seen);
        end
    endtask

`ifdef BUSMUX_DEC_LOOPBACK_EN
    task automatic test_loopback();
        for (int i = 0; i < 24; i++) begin
            send(5'(i), 5'(i % 22));
            repeat (S + 1) @(negedge clock);
        end
        checks++;
        if (chk_err !== 1'b0) begin
            errors++;
            $display("FAIL loop_clean got chk_err=%b want 0", chk_err);
        end
        send(5'd5, 5'd1);
        force u_dut.r_src_oh = 24'h000001;
        @(negedge clock);
        release u_dut.r_src_oh;
        checks++;
        if (chk_err !== 1'b1) begin
            errors++;
            $display("FAIL loop_detect got chk_err=%b want 1", chk_err);
        end
        repeat (S + 2) @(negedge clock);
        checks++;
        if (chk_err !== 1'b1) begin
            errors++;
            $display("FAIL loop_sticky got chk_err=%b want 1", chk_err);
        end
        clear = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        checks++;
        if (chk_err !== 1'b0) begin
            errors++;
            $display("FAIL loop_clear got chk_err=%b want 0", chk_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_s1();
        test_transfer();
        test_back_to_back();
        test_illegal();
        test_self();
        test_reset_mid();
`ifdef BUSMUX_DEC_LOOPBACK_EN
        test_loopback();
`endif
        repeat (2) @(negedge clock);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
